// File: rtl/sort_pkg.sv
// Shared constants and types for the sort datapath read-out side.
// Holds array geometry, the reader FSM states and the buffer entry layout.
package sort_pkg;

    localparam int DEPTH  = 32;
    localparam int ADR_W  = $clog2(DEPTH);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } rd_state_t;

    // One buffered element: data plus "came from address DEPTH-1" tag.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } rd_ent_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO absorbing the memory's one-cycle read latency.
// Ports: clk, rst (sync, high), push_i/push_ent_i, pop_i, occ_o, head_o, head_vld_o.
module rd_skid_buf
    import sort_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  rd_ent_t    push_ent_i,
    input  logic       pop_i,
    output logic [1:0] occ_o,
    output rd_ent_t    head_o,
    output logic       head_vld_o
);

    rd_ent_t    ent0_q, ent0_d;
    rd_ent_t    ent1_q, ent1_d;
    logic [1:0] occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = push_ent_i;
                else               ent1_d = push_ent_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                // Draining to empty keeps the data but drops the last tag
                // so a stale tag never shows after the run.
                if (occ_q == 2'd2) ent0_d = ent1_q;
                else               ent0_d.last = 1'b0;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_ent_i;
                end else begin
                    ent0_d = push_ent_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o      = occ_q;
    assign head_o     = ent0_q;
    assign head_vld_o = (occ_q != 2'd0);

endmodule

// File: rtl/sorted_mem_reader.sv
// Streams the sorted array out of memory over valid/ready, checking order.
// Ports: start/busy/done control, mem_rd/mem_adr/mem_data read port,
// out_valid/out_ready/out_data/out_last stream, sticky order_err flag.
module sorted_mem_reader
    import sort_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADR_W-1:0]  mem_adr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              order_err
);

    localparam logic [ADR_W:0]   DEPTH_C  = (ADR_W + 1)'(DEPTH);
    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);

    rd_state_t         state_q;
    logic [ADR_W-1:0]  adr_q;
    logic [ADR_W:0]    issued_q;
    logic              inflight_q;
    logic              infl_last_q;
    logic [DATA_W-1:0] prev_q;
    logic              have_prev_q;
    logic              err_q;
    logic              done_q;

    logic [1:0] occ;
    rd_ent_t    head;
    logic       head_vld;
    logic       pop;
    logic       issue;
    logic [2:0] pend;

    assign pop  = head_vld & out_ready;
    // Entries that will be held after this cycle if nothing new is issued.
    assign pend = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == RUN) && (issued_q < DEPTH_C) && (pend < 3'd2);

    rd_skid_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_ent_i ('{data: mem_data, last: infl_last_q}),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_o     (head),
        .head_vld_o (head_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q  <= issue;
            infl_last_q <= issue && (adr_q == LAST_ADR);
            done_q      <= 1'b0;
            if (issue) begin
                issued_q <= issued_q + 1'b1;
                if (adr_q != LAST_ADR) adr_q <= adr_q + 1'b1;
            end
            if (pop) begin
                if (have_prev_q && (head.data < prev_q)) err_q <= 1'b1;
                prev_q      <= head.data;
                have_prev_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        adr_q       <= '0;
                        issued_q    <= '0;
                        have_prev_q <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                RUN: begin
                    if (pop && head.last) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd    = issue;
    assign mem_adr   = adr_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = head_vld;
    assign out_data  = head.data;
    assign out_last  = head.last;
    assign done      = done_q;
    assign order_err = err_q;

endmodule

// File: doc/sorted_mem_reader.md
# sorted_mem_reader

Read-out side of the 32-entry, 8-bit sort datapath: once sorting finishes, this block walks the array memory from address 0 to DEPTH-1 and streams each element over a valid/ready interface. It compensates for the memory's one-cycle synchronous read latency with a 2-entry buffer, so it sustains one element per cycle under continuous `out_ready`. It also checks on the fly that the stream is non-decreasing, flagging any mis-sort. It sits between the array memory read port and the downstream consumer (display / UART / testbench sink).

## Interface
- `DEPTH`, 32, number of memory entries streamed per run
- `ADR_W`, 5, address width, equal to clog2(`DEPTH`)
- `DATA_W`, 8, element width
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to begin a run; ignored while `busy`
- `mem_rd`  out  1  memory read enable
- `mem_adr`  out  ADR_W  memory read address
- `mem_data`  in  DATA_W  memory read data, valid the cycle after `mem_rd` was sampled high
- `out_valid`  out  1  `out_data` holds an element
- `out_ready`  in  1  consumer accepts the element; a transfer occurs when `out_valid & out_ready`
- `out_data`  out  DATA_W  current element
- `out_last`  out  1  high with the element from address DEPTH-1
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse after the last transfer
- `order_err`  out  1  sticky: some transferred element was less than its predecessor

## Operation
- States: IDLE, RUN, FIN.
- IDLE → RUN on `start`. On entry: address counter = 0, issued count = 0, buffer empty, `order_err` cleared.
- RUN:
  - Issue a read when `occ + inflight - pop < 2` and fewer than DEPTH reads have been issued.
  - `occ` is buffer occupancy (0..2), `inflight` is a read issued last cycle, and `pop` is a transfer this cycle.
  - Issue means `mem_rd=1`, `mem_adr` = address counter. The counter increments and saturates at DEPTH-1, with no wrap.
- The cycle after an issue, `mem_data` is written into the buffer tail.
- `out_data` and `out_valid` always reflect the buffer head.
- `out_last` = head tag "address DEPTH-1".
- RUN → FIN on the transfer with `out_last=1`. FIN asserts `done` for one cycle, then goes to IDLE.
- `busy` = (state != IDLE).
- Order check: on each transfer after the first, set `order_err` if `out_data < prev`. Then `prev` = `out_data`. Comparison is unsigned, DATA_W bits. Equal values are legal.
- `out_valid`, once high, stays high with stable `out_data` until a transfer occurs.
- `start` in RUN or FIN is ignored and does not restart the run.
- Buffer never overflows; the issue rule guarantees `occ + inflight ≤ 2`.

## Timing
- Reset values: `mem_rd=0`, `mem_adr=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`, `done=0`, `order_err=0`. State is IDLE and buffer is empty.
- `rst` mid-run: next cycle is IDLE with all outputs at reset values. Any in-flight `mem_data` is discarded.
- `start` sampled at edge 0:
  - cycle 1: `busy=1`, `mem_rd=1`, `mem_adr=0`
  - cycle 2: `mem_data` = mem[0]
  - cycle 3: `out_valid=1`
  - Start-to-first-valid latency is 3 cycles.
- With `out_ready` held high: one transfer per cycle from cycle 3.
  - Last transfer (`out_last`) in cycle 3+DEPTH-1 = 34.
  - `done` in cycle 35; `busy=0` from cycle 36.
  - A run with no backpressure takes 35 cycles from `start`.
- Backpressure: with `out_ready=0`, issue stops once `occ + inflight = 2`.
  - Reads resume the same cycle `out_ready` returns.
  - No bubble is inserted beyond the memory latency.
- `mem_rd`, `mem_adr`, and `busy` are driven combinationally from registered state. All other outputs are registered.

## Structure
- Package `sort_pkg` holds:
  - `DEPTH`, `ADR_W`, `DATA_W` constants
  - the `rd_state_t` enum {IDLE, RUN, FIN}
- The datapath and controller import `sort_pkg`.
- One sub-module, `rd_skid_buf`:
  - 2-entry FIFO of {DATA_W data, 1-bit last}
  - ports: push, pop, occ, head outputs
  - synchronous reset to empty
- Address counter, issue logic, FSM and order checker live in `sorted_mem_reader`.

## Test plan
- Memory 0..31 ascending, `out_ready=1`, `start` at cycle 0:
  - 32 transfers in cycles 3–34, data 0..31
  - `out_last` only at cycle 34, `done` at cycle 35
  - `order_err=0`
- Same data, `out_ready` toggling 1,0,0,1 repeatedly:
  - all 32 elements in order, none duplicated or lost
  - `out_data` stable while stalled
  - `mem_rd` never leaves more than 2 entries pending
- mem[10]=5, mem[9]=9, rest ascending: `order_err` rises the cycle after transfer of address 10 and stays 1 until the next `start`.
- All entries 8'hAA: `order_err=0` (equal values legal); `out_last` on the 32nd transfer.
- `start` pulsed again in cycle 10 of a run: ignored, stream continues to address 31, exactly one `done`.
- `rst` in cycle 12 with `out_ready=0`:
  - cycle 13 shows all reset values
  - a following `start` streams from address 0 with `order_err=0`
